// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory arbiter: request/response
// structs, access-size codes, arbiter state encoding and a helper that
// widens an ibus fetch into a downstream dbus request.
package mem_bus_arbiter_pkg;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  // Wide enough for the largest legal starvation limit (15)
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // A fetch is always a 4-byte read: no strobes and no write data.
  function automatic dbus_req_t ibus_to_dbus(input ibus_req_t req);
    dbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = req.addr;
    r.size   = MSIZE4;
    r.strobe = 8'h00;
    r.data   = 64'h0;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the three request/response pairs that meet at the arbiter:
// fetch (ibus), memory stage (dbus) and the shared downstream port.
// The slave view is the arbiter itself; the master view is its environment.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;

  modport slave (
    input  ireq,
    input  dreq,
    input  oresp,
    output iresp,
    output dresp,
    output oreq
  );

  modport master (
    output ireq,
    output dreq,
    output oresp,
    input  iresp,
    input  dresp,
    input  oreq
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_prio_pick.sv
// Priority picker: dbus wins by default, ibus wins when it is alone or
// when the starvation counter has reached its limit.
module arb_prio_pick (
  input  logic ivalid_i,
  input  logic dvalid_i,
  input  logic starve_hit_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  // At most one grant; the two outputs are mutually exclusive.
  always_comb begin
    grant_i_o = ivalid_i & (~dvalid_i | starve_hit_i);
    grant_d_o = dvalid_i & ~grant_i_o;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between instruction fetch and the
// memory stage. The winning request is captured in lreq and is the only
// source for the downstream request until that transaction's data_ok,
// so requester changes or flushes never disturb an in-flight access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bus_arbiter_if.slave       bus
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              state_q, state_d;
  dbus_req_t               lreq_q, lreq_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  logic starve_hit;
  logic grant_i;
  logic grant_d;

  assign starve_hit = (starve_q == LIMIT_CNT);

  arb_prio_pick u_pick (
    .ivalid_i     (bus.ireq.valid),
    .dvalid_i     (bus.dreq.valid),
    .starve_hit_i (starve_hit),
    .grant_i_o    (grant_i),
    .grant_d_o    (grant_d)
  );

  // State, latched request and starvation counter; reset takes effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lreq_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      lreq_q   <= lreq_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration in IDLE, response routing to the owner while busy.
  always_comb begin
    state_d   = state_q;
    lreq_d    = lreq_q;
    starve_d  = starve_q;
    bus.oreq  = '0;
    bus.iresp = '0;
    bus.dresp = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          lreq_d   = ibus_to_dbus(bus.ireq);
          starve_d = '0;
          state_d  = BUSY_I;
        end else if (grant_d) begin
          lreq_d       = bus.dreq;
          lreq_d.valid = 1'b1;
          if (!bus.ireq.valid) begin
            starve_d = '0;
          end else if (!starve_hit) begin
            starve_d = starve_q + 1'b1;
          end
          state_d = BUSY_D;
        end
      end

      BUSY_I: begin
        bus.oreq          = lreq_q;
        bus.iresp.addr_ok = bus.oresp.addr_ok;
        bus.iresp.data_ok = bus.oresp.data_ok;
        bus.iresp.data    = lreq_q.addr[2] ? bus.oresp.data[63:32]
                                           : bus.oresp.data[31:0];
        if (bus.oresp.data_ok) begin
          lreq_d.valid = 1'b0;
          state_d      = IDLE;
        end
      end

      BUSY_D: begin
        bus.oreq  = lreq_q;
        bus.dresp = bus.oresp;
        if (bus.oresp.data_ok) begin
          lreq_d.valid = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
